// File: rtl/itch_book_cmd_arbiter_pkg.sv
// Shared types for the ITCH-to-order-book command arbiter: decoded message
// layouts, the book command word and the arbiter state encoding.
package itch_book_cmd_arbiter_pkg;

  localparam int TS_W             = 48;
  localparam int STALL_LIMIT_DFLT = 1024;

  typedef enum logic [1:0] {
    ADD  = 2'd0,
    DEL  = 2'd1,
    EXEC = 2'd2
  } bookOpType;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arbStateType;

  typedef struct packed {
    logic [TS_W-1:0] timeStamp;
    logic [63:0]     orderRefNum;
    logic [7:0]      buySell;
    logic [31:0]     shares;
    logic [63:0]     stock;
    logic [31:0]     price;
  } itchAddOrderType;

  typedef struct packed {
    logic [TS_W-1:0] timeStamp;
    logic [63:0]     orderRefNum;
  } itchDeleteOrderType;

  // The decoder forwards only what the book needs from an execution.
  typedef struct packed {
    logic [TS_W-1:0] timeStamp;
    logic [63:0]     orderRefNum;
  } itchOrderExecutedType;

  typedef struct packed {
    bookOpType       op;
    logic [63:0]     refNum;
    logic [7:0]      side;
    logic [31:0]     shares;
    logic [31:0]     price;
    logic [63:0]     stock;
    logic [TS_W-1:0] timeStamp;
  } bookCmdType;

  function automatic bookOpType next_op(input bookOpType op);
    case (op)
      ADD:     return DEL;
      DEL:     return EXEC;
      default: return ADD;
    endcase
  endfunction

endpackage

// File: rtl/itch_ts_min3.sv
// Three-way oldest-timestamp picker; equal minima resolved round-robin
// starting at rr_ptr. Produces a one-hot grant, or zero when nothing is valid.
module itch_ts_min3
  import itch_book_cmd_arbiter_pkg::*;
(
  input  logic [2:0]           valid,
  input  logic [2:0][TS_W-1:0] ts,
  input  bookOpType            rr_ptr,
  output logic [2:0]           grant
);

  logic [TS_W-1:0] min_ts;
  logic [2:0]      tie;
  logic [1:0]      idx;

  always_comb begin
    min_ts = '1;
    for (int i = 0; i < 3; i++)
      if (valid[i] && (ts[i] < min_ts)) min_ts = ts[i];

    for (int i = 0; i < 3; i++)
      tie[i] = valid[i] && (ts[i] == min_ts);

    // Walk ADD -> DEL -> EXEC from rr_ptr; first tied candidate wins.
    grant = '0;
    idx   = rr_ptr;
    for (int k = 0; k < 3; k++) begin
      if ((grant == 3'b000) && tie[idx]) grant[idx] = 1'b1;
      idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    end
  end

endmodule

// File: rtl/itch_book_cmd_arbiter.sv
// Merges decoded ITCH add/delete/executed streams into one registered book
// command port, oldest timestamp first, with grant counters and a stall watchdog.
module itch_book_cmd_arbiter
  import itch_book_cmd_arbiter_pkg::*;
#(
  parameter int STALL_LIMIT = STALL_LIMIT_DFLT,
  parameter int CNT_W       = 32
) (
  input  logic                 clk,
  input  logic                 rstN,
  input  logic                 addValid,
  output logic                 addReady,
  input  itchAddOrderType      addMsg,
  input  logic                 delValid,
  output logic                 delReady,
  input  itchDeleteOrderType   delMsg,
  input  logic                 exeValid,
  output logic                 exeReady,
  input  itchOrderExecutedType exeMsg,
  input  logic                 flush,
  output logic                 cmdValid,
  input  logic                 cmdReady,
  output logic [1:0]           cmdOp,
  output logic [63:0]          cmdRefNum,
  output logic [7:0]           cmdSide,
  output logic [31:0]          cmdShares,
  output logic [31:0]          cmdPrice,
  output logic [63:0]          cmdStock,
  output logic [TS_W-1:0]      cmdTimeStamp,
  output logic [CNT_W-1:0]     addCnt,
  output logic [CNT_W-1:0]     delCnt,
  output logic [CNT_W-1:0]     exeCnt,
  output logic                 stallErr
);

  localparam int SC_W = $clog2(STALL_LIMIT + 1);

  arbStateType          state, state_nxt;
  bookOpType            rr_ptr;
  bookCmdType           cmd_q, cand;
  logic [2:0]           valid, grant;
  logic [2:0][TS_W-1:0] ts;
  logic                 hshk, load_ok, load;
  logic [SC_W-1:0]      stall_cnt, stall_nxt;

  assign valid = {exeValid, delValid, addValid};
  assign ts    = {exeMsg.timeStamp, delMsg.timeStamp, addMsg.timeStamp};

  itch_ts_min3 u_pick (
    .valid  (valid),
    .ts     (ts),
    .rr_ptr (rr_ptr),
    .grant  (grant)
  );

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) state <= IDLE;
    else       state <= state_nxt;
  end

  // rstN gating keeps the readys low while the block is held in reset.
  always_comb begin
    hshk      = (state == HOLD) && cmdReady;
    load_ok   = rstN && !flush && ((state == IDLE) || hshk);
    load      = load_ok && (grant != 3'b000);
    addReady  = load_ok && grant[0];
    delReady  = load_ok && grant[1];
    exeReady  = load_ok && grant[2];
    state_nxt = state;
    if (flush)     state_nxt = IDLE;
    else if (load) state_nxt = HOLD;
    else if (hshk) state_nxt = IDLE;
  end

  always_comb begin
    cand = '0;
    if (grant[0]) begin
      cand.op        = ADD;
      cand.refNum    = addMsg.orderRefNum;
      cand.side      = addMsg.buySell;
      cand.shares    = addMsg.shares;
      cand.price     = addMsg.price;
      cand.stock     = addMsg.stock;
      cand.timeStamp = addMsg.timeStamp;
    end else if (grant[1]) begin
      cand.op        = DEL;
      cand.refNum    = delMsg.orderRefNum;
      cand.timeStamp = delMsg.timeStamp;
    end else if (grant[2]) begin
      cand.op        = EXEC;
      cand.refNum    = exeMsg.orderRefNum;
      cand.timeStamp = exeMsg.timeStamp;
    end
  end

  // Counts consecutive blocked cycles; HOLD without handshake means cmdReady=0.
  always_comb begin
    stall_nxt = stall_cnt;
    if (flush || hshk)
      stall_nxt = '0;
    else if ((state == HOLD) && (stall_cnt != SC_W'(STALL_LIMIT)))
      stall_nxt = stall_cnt + SC_W'(1);
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      rr_ptr    <= ADD;
      cmd_q     <= '0;
      addCnt    <= '0;
      delCnt    <= '0;
      exeCnt    <= '0;
      stall_cnt <= '0;
      stallErr  <= 1'b0;
    end else begin
      stall_cnt <= stall_nxt;
      if (stall_nxt == SC_W'(STALL_LIMIT)) stallErr <= 1'b1;
      if (load) begin
        cmd_q  <= cand;
        rr_ptr <= next_op(cand.op);
        if (grant[0]) addCnt <= addCnt + CNT_W'(1);
        if (grant[1]) delCnt <= delCnt + CNT_W'(1);
        if (grant[2]) exeCnt <= exeCnt + CNT_W'(1);
      end
    end
  end

  assign cmdValid     = (state == HOLD);
  assign cmdOp        = cmd_q.op;
  assign cmdRefNum    = cmd_q.refNum;
  assign cmdSide      = cmd_q.side;
  assign cmdShares    = cmd_q.shares;
  assign cmdPrice     = cmd_q.price;
  assign cmdStock     = cmd_q.stock;
  assign cmdTimeStamp = cmd_q.timeStamp;

endmodule
